// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte producers.
// Optional watchdog/ABORT path enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int TO_CYCLES = 100000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ*DW-1:0] req_data_i,
   output logic [NREQ-1:0]    ack_o,
   output logic               tx_start_o,
   output logic [DW-1:0]      tx_data_o,
   input  logic               tx_done_i,
   output logic               busy_o,
   output logic [2:0]         owner_o,
   output logic               err_timeout_o
);

`ifdef UART_SCHED_TIMEOUT_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_DONE   = 3'd3,
      S_ABORT  = 3'd4
   } state_t;

   localparam int WDW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
   localparam logic [WDW-1:0] WD_LIM = WDW'(TO_CYCLES - 1);

   logic [WDW-1:0] wd_q, wd_d;
   logic           err_q, err_d;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_DONE   = 3'd3
   } state_t;
`endif

   state_t         state_q, state_d;
   logic [2:0]     ptr_q, ptr_d;
   logic [2:0]     owner_q, owner_d;
   logic [DW-1:0]  tx_data_q, tx_data_d;
   logic           tx_start_q, tx_start_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic           busy_q, busy_d;

   logic [7:0]     req_ext;
   logic           found;
   logic [2:0]     pick;
   logic [2:0]     cand;
   logic [DW-1:0]  data_sel;

   function automatic logic [2:0] next_idx(input logic [2:0] idx);
      return (idx == 3'(NREQ - 1)) ? 3'd0 : idx + 3'd1;
   endfunction

   // First pending request at or after ptr, wrapping modulo NREQ.
   always_comb begin
      req_ext  = 8'(req_i);
      found    = 1'b0;
      pick     = ptr_q;
      cand     = '0;
      data_sel = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = 3'((int'(ptr_q) + k) % NREQ);
         if (!found && req_ext[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (pick == 3'(i)) data_sel = req_data_i[i*DW +: DW];
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      ack_d      = '0;
`ifdef UART_SCHED_TIMEOUT_EN
      wd_d       = wd_q;
      err_d      = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d    = S_LAUNCH;
               owner_d    = pick;
               tx_data_d  = data_sel;
               tx_start_d = 1'b1;
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT;
`ifdef UART_SCHED_TIMEOUT_EN
            wd_d    = '0;
`endif
         end
         S_WAIT: begin
            // A completion arriving on the limit cycle still counts as success.
            if (tx_done_i) begin
               state_d = S_DONE;
               ack_d   = NREQ'(1) << owner_q;
            end
`ifdef UART_SCHED_TIMEOUT_EN
            else if (wd_q == WD_LIM) begin
               state_d = S_ABORT;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end
         S_DONE: begin
            ptr_d   = next_idx(owner_q);
            state_d = S_IDLE;
         end
`ifdef UART_SCHED_TIMEOUT_EN
         S_ABORT: begin
            ptr_d   = next_idx(owner_q);
            state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         ack_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
      end
   end

`ifdef UART_SCHED_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end
   assign err_timeout_o = err_q;
`else
   assign err_timeout_o = 1'b0;
`endif

   assign ack_o      = ack_q;
   assign tx_start_o = tx_start_q;
   assign tx_data_o  = tx_data_q;
   assign busy_o     = busy_q;
   assign owner_o    = owner_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched against a round-robin reference model.
module tb_uart_tx_sched;
   localparam int NREQ = 4;
   localparam int DW   = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic        tx_done = 1'b0;
   logic [3:0]  ack;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        busy;
   logic [2:0]  owner;
   logic        err_timeout;

   int checks = 0;
   int errors = 0;
   int ptr_m  = 0;

   always #5 clk = ~clk;

   uart_tx_sched #(.NREQ(NREQ), .DW(DW), .TO_CYCLES(16)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .req_data_i(req_data),
      .ack_o(ack), .tx_start_o(tx_start), .tx_data_o(tx_data),
      .tx_done_i(tx_done), .busy_o(busy), .owner_o(owner),
      .err_timeout_o(err_timeout)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference arbitration: first pending index at or after p, modulo NREQ.
   function automatic int rr_pick(input logic [3:0] m, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (m[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic do_reset;
      rst = 1'b1; req = '0; tx_done = 1'b0;
      tick;
      rst = 1'b0;
      ptr_m = 0;
   endtask

   task automatic test_reset;
      rst = 1'b1; req = 4'b1111; req_data = 32'h13121110;
      for (int c = 0; c < 2; c++) begin
         tick;
         checks++;
         if ({tx_start, ack, busy, owner, tx_data, err_timeout} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got start=%b ack=%b busy=%b owner=%0d data=%h err=%b required all 0",
                     tx_start, ack, busy, owner, tx_data, err_timeout);
         end
      end
      rst = 1'b0; req = '0; ptr_m = 0;
      tick;
      checks++;
      if ({tx_start, busy} !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle: got start=%b busy=%b required 0 0", tx_start, busy);
      end
   endtask

   task automatic test_single;
      int starts;
      req_data = {8'($urandom), 8'hA5, 8'($urandom), 8'($urandom)};
      req = 4'b0100;
      tick;
      checks++;
      if ({tx_start, busy, owner, tx_data} !== {1'b1, 1'b1, 3'd2, 8'hA5}) begin
         errors++;
         $display("FAIL single_launch: got start=%b busy=%b owner=%0d data=%h required 1 1 2 a5",
                  tx_start, busy, owner, tx_data);
      end
      starts = 0;
      for (int c = 0; c < 10; c++) begin
         tick;
         if (tx_start) starts++;
         if (ack !== 4'b0000) starts += 100;
      end
      checks++;
      if (starts != 0) begin
         errors++;
         $display("FAIL single_wait: got extra start/ack code %0d required 0", starts);
      end
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0; req = '0;
      checks++;
      if ({ack, tx_data, owner} !== {4'b0100, 8'hA5, 3'd2}) begin
         errors++;
         $display("FAIL single_ack: got ack=%b data=%h owner=%0d required 0100 a5 2", ack, tx_data, owner);
      end
      ptr_m = 3;
      tick;
      checks++;
      if ({ack, busy} !== 5'b0) begin
         errors++;
         $display("FAIL single_idle: got ack=%b busy=%b required 0000 0", ack, busy);
      end
   endtask

   task automatic test_fairness;
      int exp_seq[5] = '{0, 1, 2, 3, 0};
      do_reset;
      req = 4'b1111; req_data = 32'h13121110;
      for (int n = 0; n < 5; n++) begin
         tick;
         checks++;
         if ({tx_start, owner, tx_data} !== {1'b1, 3'(exp_seq[n]), 8'(8'h10 + exp_seq[n])}) begin
            errors++;
            $display("FAIL fair_launch%0d: got start=%b owner=%0d data=%h required 1 %0d %h",
                     n, tx_start, owner, tx_data, exp_seq[n], 8'h10 + exp_seq[n]);
         end
         tick;
         tick;
         tx_done = 1'b1;
         tick;
         tx_done = 1'b0;
         checks++;
         if (ack !== 4'(1 << exp_seq[n])) begin
            errors++;
            $display("FAIL fair_ack%0d: got %b required %b", n, ack, 4'(1 << exp_seq[n]));
         end
         tick;
      end
      req = '0;
      tick; tick; tick;
      ptr_m = 1;
   endtask

   task automatic test_drop_and_reset;
      req = 4'b0010; req_data = 32'h0000_5A00;
      tick;
      tick;
      req = 4'b0000;
      tick; tick;
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      checks++;
      if (ack !== 4'b0010) begin
         errors++;
         $display("FAIL drop_ack: got %b required 0010", ack);
      end
      tick;
      req = 4'b0010;
      tick;
      tick;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0; req = '0; ptr_m = 0;
      checks++;
      if ({busy, ack, tx_start, owner} !== 9'd0) begin
         errors++;
         $display("FAIL rst_mid_wait: got busy=%b ack=%b start=%b owner=%0d required all 0",
                  busy, ack, tx_start, owner);
      end
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      tick;
      checks++;
      if ({busy, ack} !== 5'd0) begin
         errors++;
         $display("FAIL rst_no_ack: got busy=%b ack=%b required 0 0000", busy, ack);
      end
   endtask

   task automatic test_stray_done;
      logic bad;
      do_reset;
      tick;
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      checks++;
      if ({ack, busy, tx_start} !== 6'd0) begin
         errors++;
         $display("FAIL stray_idle: got ack=%b busy=%b start=%b required 0", ack, busy, tx_start);
      end
      req = 4'b0001; req_data = 32'h0000_00C3;
      tick;
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (ack !== 4'b0000 || busy !== 1'b1) bad = 1'b1;
         tick;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL stray_launch: got early ack or idle=%b required 0", bad);
      end
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0; req = '0;
      checks++;
      if (ack !== 4'b0001) begin
         errors++;
         $display("FAIL stray_wait_ack: got %b required 0001", ack);
      end
      tick;
      ptr_m = 1;
   endtask

   task automatic test_random;
      logic [3:0] pend;
      int exp_o, lat;
      do_reset;
      pend = '0;
      tick;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               req_data[i*8 +: 8] = 8'($urandom);
            end
         end
         if (pend == 4'b0) pend[$urandom_range(0, 3)] = 1'b1;
         req = pend;
         exp_o = rr_pick(pend, ptr_m);
         tick;
         checks++;
         if ({tx_start, busy, owner, tx_data} !== {1'b1, 1'b1, 3'(exp_o), req_data[exp_o*8 +: 8]}) begin
            errors++;
            $display("FAIL rand_launch%0d: got start=%b busy=%b owner=%0d data=%h required 1 1 %0d %h",
                     t, tx_start, busy, owner, tx_data, exp_o, req_data[exp_o*8 +: 8]);
         end
         tick;
         if ($urandom_range(0, 3) == 0) req[exp_o] = 1'b0;
         lat = $urandom_range(0, 5);
         repeat (lat) tick;
         tx_done = 1'b1;
         tick;
         tx_done = 1'b0;
         checks++;
         if ({ack, tx_start} !== {4'(1 << exp_o), 1'b0}) begin
            errors++;
            $display("FAIL rand_ack%0d: got ack=%b start=%b required %b 0", t, ack, tx_start, 4'(1 << exp_o));
         end
         ptr_m = (exp_o + 1) % NREQ;
         pend[exp_o] = ($urandom_range(0, 3) == 0);
         req = pend;
         tick;
         checks++;
         if ({busy, ack} !== 5'd0) begin
            errors++;
            $display("FAIL rand_idle%0d: got busy=%b ack=%b required 0 0000", t, busy, ack);
         end
      end
      req = '0;
      tick;
   endtask

`ifdef UART_SCHED_TIMEOUT_EN
   task automatic test_timeout;
      logic bad;
      do_reset;
      req = 4'b0011; req_data = 32'h0000_2211;
      tick;
      bad = 1'b0;
      for (int c = 0; c < 16; c++) begin
         tick;
         if (err_timeout !== 1'b0 || ack !== 4'b0 || busy !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL to_early: got premature err/ack/idle=%b required 0", bad);
      end
      tick;
      checks++;
      if ({err_timeout, ack} !== {1'b1, 4'b0}) begin
         errors++;
         $display("FAIL to_abort: got err=%b ack=%b required 1 0000", err_timeout, ack);
      end
      tick;
      tick;
      checks++;
      if ({tx_start, owner, tx_data, err_timeout} !== {1'b1, 3'd1, 8'h22, 1'b1}) begin
         errors++;
         $display("FAIL to_next: got start=%b owner=%0d data=%h err=%b required 1 1 22 1",
                  tx_start, owner, tx_data, err_timeout);
      end
      tick;
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0; req = '0;
      checks++;
      if (ack !== 4'b0010) begin
         errors++;
         $display("FAIL to_next_ack: got %b required 0010", ack);
      end
      do_reset;
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL to_clear: got %b required 0", err_timeout);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_single;
      test_fairness;
      test_drop_and_reset;
      test_stray_done;
      test_random;
`ifdef UART_SCHED_TIMEOUT_EN
      test_timeout;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
